// File: rtl/serial_frame_rx_if.sv
// Bundle for the serial receiver's line input and its byte FIFO output.
interface serial_frame_rx_if #(parameter int FIFO_LOG2 = 2);
  logic                 rx;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overflow;
  logic [FIFO_LOG2:0]   fill;

  modport master (input rx, rx_ready, output rx_data, rx_valid, frame_err, overflow, fill);
  modport slave  (output rx, rx_ready, input rx_data, rx_valid, frame_err, overflow, fill);
endinterface

// File: rtl/serial_frame_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM and a small
// circular receive FIFO with overflow and framing-error pulses.
module serial_frame_rx #(
  parameter int CLK_PER_BIT = 250,
  parameter int FIFO_LOG2   = 2
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_rx_if.master bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]        CNT_BIT  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]        CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
  localparam logic [FIFO_LOG2:0]   FILL_ONE = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2:0]   FILL_MAX = (FIFO_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state, w_state_nx;
  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic [2:0]           r_bitn, w_bitn_nx;
  logic [7:0]           r_shift, w_shift_nx;
  logic                 r_armed, w_armed_nx;
  logic                 w_tick, w_push, w_bad;

  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wp, r_rp;
  logic [FIFO_LOG2:0]   r_fill;
  logic                 r_ferr, r_ovf;
  logic                 w_full, w_pop, w_wr;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], bus.rx};

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bitn  <= w_bitn_nx;
      r_shift <= w_shift_nx;
      r_armed <= w_armed_nx;
    end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bitn_nx  = r_bitn;
    w_shift_nx = r_shift;
    w_armed_nx = r_armed;
    w_push     = 1'b0;
    w_bad      = 1'b0;
    case (r_state)
      IDLE: begin
        // A line held low after a framing error must go high before re-arming.
        if (w_rx_s) w_armed_nx = 1'b1;
        else if (r_armed) begin
          w_state_nx = START;
          w_cnt_nx   = CNT_HALF;
        end
      end
      START: begin
        if (!w_tick) w_cnt_nx = r_cnt - CNT_ONE;
        else if (!w_rx_s) begin
          w_state_nx = DATA;
          w_cnt_nx   = CNT_BIT;
          w_bitn_nx  = '0;
        end else w_state_nx = IDLE;
      end
      DATA: begin
        if (!w_tick) w_cnt_nx = r_cnt - CNT_ONE;
        else begin
          w_shift_nx = {w_rx_s, r_shift[7:1]};
          w_cnt_nx   = CNT_BIT;
          w_bitn_nx  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) w_state_nx = STOP;
        end
      end
      STOP: begin
        if (!w_tick) w_cnt_nx = r_cnt - CNT_ONE;
        else begin
          w_state_nx = IDLE;
          if (w_rx_s) w_push = 1'b1;
          else begin
            w_bad      = 1'b1;
            w_armed_nx = 1'b0;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_full = (r_fill == FILL_MAX);
  assign w_pop  = (r_fill != '0) && bus.rx_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + PTR_ONE;
      if (w_pop) r_rp <= r_rp + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
      r_ferr <= w_bad;
      r_ovf  <= w_push && !w_wr;
    end

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= r_shift;

  assign bus.rx_data   = r_mem[r_rp];
  assign bus.rx_valid  = (r_fill != '0);
  assign bus.frame_err = r_ferr;
  assign bus.overflow  = r_ovf;
  assign bus.fill      = r_fill;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random traffic, checked each
// cycle against a queue model of the receive FIFO.
module tb_serial_frame_rx;
  localparam int CPB   = 16;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;
  localparam int H     = CPB / 2;

  logic clk = 1'b0;
  logic rst;

  serial_frame_rx_if #(.FIFO_LOG2(LOG2)) bus ();
  serial_frame_rx #(.CLK_PER_BIT(CPB), .FIFO_LOG2(LOG2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ferr_seen = 0, ovf_seen = 0;
  logic [7:0] model_q[$];
  logic [7:0] got_q[$];
  logic stop_flag, stop_good, exp_ferr = 1'b0, exp_ovf = 1'b0;
  logic [7:0] stop_byte;
  logic rand_en, ready_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2 bus.rx_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Queue model: a good stop bit enqueues unless full with no pop; outputs lag one edge.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      chk("rx_valid", bus.rx_valid, model_q.size() != 0);
      chk("fill", bus.fill, model_q.size());
      if (model_q.size() != 0) chk("rx_data", bus.rx_data, model_q[0]);
      chk("frame_err", bus.frame_err, exp_ferr);
      chk("overflow", bus.overflow, exp_ovf);
      chk("ferr_ovf_excl", bus.frame_err & bus.overflow, 1'b0);
      ferr_seen += int'(bus.frame_err);
      ovf_seen  += int'(bus.overflow);
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      if (bus.rx_ready && model_q.size() != 0) begin
        got_q.push_back(bus.rx_data);
        void'(model_q.pop_front());
      end
      if (stop_flag) begin
        if (!stop_good) exp_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(stop_byte);
        else exp_ovf = 1'b1;
      end
    end
  end

  // Stop sample falls 3 + H + 9*CPB edges after rx drops: 2 sync flops, 1 detect edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap, input logic pop_at_stop);
    @(posedge clk); #1 bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 bus.rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 bus.rx = stop;
    repeat (H + 2) @(posedge clk);
    #1 stop_flag = 1'b1; stop_good = stop; stop_byte = b;
    if (pop_at_stop) ready_force = 1'b1;
    @(posedge clk);
    #1 stop_flag = 1'b0;
    if (pop_at_stop) ready_force = 1'b0;
    repeat (CPB - H - 3) @(posedge clk);
    if (gap > 0) begin
      #1 bus.rx = 1'b1;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic drain();
    @(posedge clk); #1 ready_force = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1 ready_force = 1'b0;
    @(posedge clk); #3;
    chk("drained", bus.rx_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, o0, base;
    logic [7:0] exp4[4];
    logic [7:0] pre, b;
    logic good;
    bus.rx = 1'b1; ready_force = 1'b0; rand_en = 1'b0;
    stop_flag = 1'b0; stop_good = 1'b1; stop_byte = 8'h00;
    rst = 1'b0; #1 rst = 1'b1; #2;
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_fill", bus.fill, 0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);

    // single good byte, consumer idle
    send_frame(8'hA5, 1'b1, 2 * CPB, 1'b0);
    #2;
    chk("a5_valid", bus.rx_valid, 1'b1);
    chk("a5_data", bus.rx_data, 8'hA5);
    chk("a5_fill", bus.fill, 1);
    chk("a5_ferr", ferr_seen, 0);
    drain();

    // 5-cycle glitch is rejected silently
    @(posedge clk); #1 bus.rx = 1'b0;
    repeat (5) @(posedge clk); #1 bus.rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #2;
    chk("glitch_valid", bus.rx_valid, 1'b0);
    chk("glitch_ferr", ferr_seen, 0);

    // bad stop then a long break: exactly one frame_err
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    repeat (40 * CPB) @(posedge clk);
    chk("brk_ferr", ferr_seen - f0, 1);
    chk("brk_fill", bus.fill, 0);
    #1 bus.rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    base = got_q.size();
    send_frame(8'h11, 1'b1, 2 * CPB, 1'b0);
    drain();
    chk("after_brk_cnt", got_q.size() - base, 1);
    if (got_q.size() > base) chk("after_brk_data", got_q[base], 8'h11);

    // overflow on the fifth byte
    o0 = ovf_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 2 * CPB, 1'b0);
    chk("ovf_fill", bus.fill, 4);
    chk("ovf_count", ovf_seen - o0, 1);
    base = got_q.size();
    drain();
    exp4 = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk("ovf_pops", got_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < got_q.size()) chk("ovf_order", got_q[base + i], exp4[i]);

    // push into a full FIFO with a simultaneous pop
    o0 = ovf_seen;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 2 * CPB, 1'b0);
    base = got_q.size();
    send_frame(8'h05, 1'b1, 2 * CPB, 1'b1);
    chk("pp_fill", bus.fill, 4);
    chk("pp_ovf", ovf_seen - o0, 0);
    if (got_q.size() > base) chk("pp_first", got_q[base], 8'h01);
    drain();
    exp4 = '{8'h02, 8'h03, 8'h04, 8'h05};
    chk("pp_pops", got_q.size() - base, 5);
    for (int i = 0; i < 4; i++)
      if (base + 1 + i < got_q.size()) chk("pp_order", got_q[base + 1 + i], exp4[i]);

    // reset during data bit 4 with a byte already queued
    send_frame(8'h77, 1'b1, 2 * CPB, 1'b0);
    pre = 8'h96;
    @(posedge clk); #1 bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 bus.rx = pre[i];
      repeat (CPB) @(posedge clk);
    end
    #1 bus.rx = pre[4];
    repeat (H) @(posedge clk);
    #1 rst = 1'b1; bus.rx = 1'b1;
    #1;
    chk("mid_rst_valid", bus.rx_valid, 1'b0);
    chk("mid_rst_fill", bus.fill, 0);
    chk("mid_rst_ferr", bus.frame_err, 1'b0);
    chk("mid_rst_ovf", bus.overflow, 1'b0);
    repeat (4) @(posedge clk); #1 rst = 1'b0;
    f0 = ferr_seen;
    base = got_q.size();
    repeat (2 * CPB) @(posedge clk);
    send_frame(8'hC3, 1'b1, 2 * CPB, 1'b0);
    drain();
    chk("rst_rx_cnt", got_q.size() - base, 1);
    if (got_q.size() > base) chk("rst_rx_data", got_q[base], 8'hC3);
    chk("rst_ferr_none", ferr_seen - f0, 0);

    // random bytes, stop bits and consumer
    rand_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, CPB + int'($urandom_range(0, 2 * CPB)), 1'b0);
    end
    rand_en = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter CLK_PER_BIT, default 250, clk cycles per serial bit; legal values are even and at least 8.
REQ-002 Parameter FIFO_LOG2, default 2, log2 of the receive FIFO depth (default depth 4).
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1.
REQ-007 rx_valid  output  1  FIFO non-empty.
REQ-008 rx_ready  input  1  consumer pop request; a pop occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-009 frame_err  output  1  one-cycle pulse when a bad stop bit is detected.
REQ-010 overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 fill  output  FIFO_LOG2+1  current FIFO occupancy.

Function
REQ-012 rx shall pass through a 2-flop synchronizer initialised to 1; all decisions use the synchronized value rx_s.
REQ-013 The FSM shall have four states: IDLE, START, DATA and STOP.
REQ-014 IDLE: rx_s=0 -> START, with the bit counter loaded so the next sample falls CLK_PER_BIT/2 cycles later.
REQ-015 START: at the half-bit sample, rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected, no output, no error).
REQ-016 DATA: sample rx_s every CLK_PER_BIT cycles, 8 samples, LSB first, into a shift register; after the 8th sample -> STOP.
REQ-017 STOP: sample CLK_PER_BIT cycles after the 8th data sample; rx_s=1 -> push the byte and go to IDLE; rx_s=0 -> pulse frame_err, discard the byte, and go to IDLE.
REQ-018 After a frame_err the FSM shall not re-arm until rx_s=1 has been seen (break condition does not retrigger).
REQ-019 Latency: rx_valid shall rise exactly 1 cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-020 FIFO: circular buffer, 2**FIFO_LOG2 entries, read/write pointers of FIFO_LOG2 bits, wrap-around modulo depth; rx_data is the entry at the read pointer, combinational from storage.
REQ-021 Push when full and no pop in the same cycle: byte dropped, overflow pulses, FIFO contents unchanged.
REQ-022 Push when full with a pop in the same cycle: both occur, no overflow, fill unchanged.
REQ-023 Push and pop in the same cycle at any other fill level: fill unchanged, order preserved.
REQ-024 Pop when empty shall be ignored; fill never underflows.
REQ-025 fill shall range 0..2**FIFO_LOG2; rx_valid = (fill != 0).
REQ-026 frame_err and overflow shall never assert in the same cycle, since each results from a single stop-bit decision.

Reset
REQ-027 On rst=1, immediately and regardless of clk: FSM=IDLE, synchronizer=1, pointers=0, fill=0, rx_valid=0, frame_err=0, overflow=0, rx_data=don't-care.
REQ-028 Reset asserted mid-frame shall abandon the partial byte; after release the receiver waits for a fresh falling edge.
REQ-029 FIFO storage contents need not be reset.

Verification (CLK_PER_BIT=16, FIFO_LOG2=2)
REQ-030 Send 8'hA5 with a good stop bit, rx_ready=0 -> rx_valid=1 with rx_data=8'hA5 at 1 cycle after the stop sample; fill=1; frame_err=0.
REQ-031 Drive a 5-cycle low glitch on idle rx -> no state beyond START, rx_valid stays 0, frame_err=0.
REQ-032 Send 8'h3C with stop bit=0 -> frame_err pulses exactly once, fill=0; hold rx low for 40 bit times -> no further frame_err; then send 8'h11 -> received correctly.
REQ-033 Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with rx_ready=0 -> fill=4, overflow pulses once on the 5th byte; pops then yield 01, 02, 03, 04, then rx_valid=0.
REQ-034 With FIFO full, hold rx_ready=1 on the cycle the 5th byte is pushed -> no overflow, fill stays 4, and the subsequent pop order is 02, 03, 04, 05.
REQ-035 Assert rst during data bit 4 of a frame, release it, then send 8'hC3 -> only 8'hC3 is received, all outputs are 0 during reset, and no frame_err occurs.
